// File: rtl/mpeg2_pkg.sv
// Shared encodings and the controller state type for the MPEG2 motion-search datapath.
package mpeg2_pkg;

    localparam logic [1:0] CC_Y = 2'b00;
    localparam logic [1:0] CC_U = 2'b01;
    localparam logic [1:0] CC_V = 2'b10;

    localparam int MB_SIZE  = 16;
    localparam int ACCW     = 18;
    localparam int BUSY_TMO = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SCAN,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_FINAL_ISSUE,
        S_F_WAIT_BUSY,
        S_F_WAIT_DONE,
        S_DONE
    } mv_state_e;

    // Chroma vector: arithmetic shift right by one (-3 -> -2, +3 -> +1).
    function automatic logic [4:0] half_vec(input logic [4:0] v);
        return {v[4], v[4:1]};
    endfunction

endpackage

// File: rtl/mv_candidate_gen.sv
// Walks the candidate vectors dy-outer/dx-inner over [-RANGE,+RANGE] and flags
// candidates whose reference block would fall outside the frame.
module mv_candidate_gen #(
    parameter int RANGE = 4,
    parameter int MBW   = 22,
    parameter int MBH   = 18
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       init_i,
    input  logic       next_i,
    input  logic [4:0] mb_x_i,
    input  logic [4:0] mb_y_i,
    output logic [4:0] dx_o,
    output logic [4:0] dy_o,
    output logic       clip_o,
    output logic       last_o
);
    import mpeg2_pkg::*;

    // One bit above what legal macroblocks need, so even mb_x/mb_y = 31 cannot wrap.
    localparam int CW = 11;
    localparam logic [4:0]           R_POS   = 5'(RANGE);
    localparam logic [4:0]           R_NEG   = 5'(-RANGE);
    localparam logic signed [CW-1:0] X_LAST  = CW'(MB_SIZE * MBW - 1);
    localparam logic signed [CW-1:0] Y_LAST  = CW'(MB_SIZE * MBH - 1);
    localparam logic signed [CW-1:0] MB_SPAN = CW'(MB_SIZE - 1);

    logic [4:0] dx_q, dx_d, dy_q, dy_d;
    logic signed [CW-1:0] x0, y0, x1, y1;

    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        if (init_i) begin
            dx_d = R_NEG;
            dy_d = R_NEG;
        end else if (next_i) begin
            if (dx_q == R_POS) begin
                dx_d = R_NEG;
                dy_d = dy_q + 5'd1;
            end else begin
                dx_d = dx_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dx_q <= '0;
            dy_q <= '0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    // Macroblock origin is mb * 16: append four zero bits.
    assign x0 = $signed({{(CW-9){1'b0}}, mb_x_i, 4'b0000}) + $signed({{(CW-5){dx_q[4]}}, dx_q});
    assign y0 = $signed({{(CW-9){1'b0}}, mb_y_i, 4'b0000}) + $signed({{(CW-5){dy_q[4]}}, dy_q});
    assign x1 = x0 + MB_SPAN;
    assign y1 = y0 + MB_SPAN;

    assign clip_o = (x0[CW-1] || (x1 > X_LAST) || y0[CW-1] || (y1 > Y_LAST))
                    && !((dx_q == 5'd0) && (dy_q == 5'd0));
    assign last_o = (dx_q == R_POS) && (dy_q == R_POS);
    assign dx_o   = dx_q;
    assign dy_o   = dy_q;

endmodule

// File: rtl/mv_search_ctrl.sv
// Full-search motion estimation sequencer: drives blkcompare over every candidate,
// tracks the lowest SAD, then replays the winner for Y, U and V residual output.
//
//  state         | meaning
//  S_IDLE        | waiting for start
//  S_SCAN        | evaluate clipping of current candidate (skip or issue)
//  S_ISSUE       | wait for rdy, pulse cmp_en for a luma candidate
//  S_WAIT_BUSY   | wait for blkcompare to drop rdy (or timeout)
//  S_WAIT_DONE   | wait for rdy, collect SAD, update best
//  S_FINAL_ISSUE | wait for rdy, pulse cmp_en for a final Y/U/V pass
//  S_F_WAIT_BUSY | as S_WAIT_BUSY for final pass
//  S_F_WAIT_DONE | as S_WAIT_DONE, result discarded
//  S_DONE        | one-cycle done pulse
module mv_search_ctrl #(
    parameter int RANGE = 4,
    parameter int MBW   = 22,
    parameter int MBH   = 18,
    parameter int ACCW  = mpeg2_pkg::ACCW
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start_i,
    input  logic [4:0]      mb_x_i,
    input  logic [4:0]      mb_y_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            cmp_en_o,
    output logic [1:0]      cmp_cc_o,
    output logic [ACCW-1:0] cmp_oldaccum_o,
    input  logic            cmp_rdy_i,
    input  logic [ACCW-1:0] cmp_accum_i,
    input  logic            cmp_valid_i,
    output logic [4:0]      ref_dx_o,
    output logic [4:0]      ref_dy_o,
    output logic [4:0]      best_dx_o,
    output logic [4:0]      best_dy_o,
    output logic [ACCW-1:0] best_sad_o,
    output logic [6:0]      cand_cnt_o
);
    import mpeg2_pkg::*;

    localparam logic [ACCW-1:0] SAD_MAX = '1;

    mv_state_e       state_q, state_d;
    logic [4:0]      mb_x_q, mb_x_d, mb_y_q, mb_y_d;
    logic [4:0]      best_dx_q, best_dx_d, best_dy_q, best_dy_d;
    logic [ACCW-1:0] best_sad_q, best_sad_d;
    logic [6:0]      cnt_q, cnt_d;
    logic [4:0]      ref_dx_q, ref_dx_d, ref_dy_q, ref_dy_d;
    logic [1:0]      cc_q, cc_d;
    logic [ACCW-1:0] old_q, old_d;
    logic [1:0]      pass_q, pass_d;
    logic [3:0]      tmr_q, tmr_d;

    logic       cand_init, cand_next, cand_clip, cand_last;
    logic [4:0] cand_dx, cand_dy;
    logic       cmp_en, go_final;

    mv_candidate_gen #(.RANGE(RANGE), .MBW(MBW), .MBH(MBH)) u_cand (
        .clk     (clk),
        .reset_n (reset_n),
        .init_i  (cand_init),
        .next_i  (cand_next),
        .mb_x_i  (mb_x_q),
        .mb_y_i  (mb_y_q),
        .dx_o    (cand_dx),
        .dy_o    (cand_dy),
        .clip_o  (cand_clip),
        .last_o  (cand_last)
    );

    always_comb begin
        state_d    = state_q;
        mb_x_d     = mb_x_q;
        mb_y_d     = mb_y_q;
        best_dx_d  = best_dx_q;
        best_dy_d  = best_dy_q;
        best_sad_d = best_sad_q;
        cnt_d      = cnt_q;
        ref_dx_d   = ref_dx_q;
        ref_dy_d   = ref_dy_q;
        cc_d       = cc_q;
        old_d      = old_q;
        pass_d     = pass_q;
        tmr_d      = tmr_q;
        cand_init  = 1'b0;
        cand_next  = 1'b0;
        cmp_en     = 1'b0;
        go_final   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mb_x_d     = mb_x_i;
                    mb_y_d     = mb_y_i;
                    best_sad_d = SAD_MAX;
                    best_dx_d  = '0;
                    best_dy_d  = '0;
                    cnt_d      = '0;
                    cand_init  = 1'b1;
                    state_d    = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!cand_clip) begin
                    ref_dx_d = cand_dx;
                    ref_dy_d = cand_dy;
                    cc_d     = CC_Y;
                    old_d    = best_sad_q;
                    state_d  = S_ISSUE;
                end else if (cand_last) begin
                    go_final = 1'b1;
                end else begin
                    cand_next = 1'b1;
                end
            end
            S_ISSUE, S_FINAL_ISSUE: begin
                if (cmp_rdy_i) begin
                    cmp_en  = 1'b1;
                    tmr_d   = 4'(BUSY_TMO - 1);
                    state_d = (state_q == S_ISSUE) ? S_WAIT_BUSY : S_F_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY, S_F_WAIT_BUSY: begin
                // A blkcompare that never drops rdy is treated as having gone busy.
                if (!cmp_rdy_i || (tmr_q == 4'd0)) begin
                    state_d = (state_q == S_WAIT_BUSY) ? S_WAIT_DONE : S_F_WAIT_DONE;
                end else begin
                    tmr_d = tmr_q - 4'd1;
                end
            end
            S_WAIT_DONE: begin
                if (cmp_rdy_i) begin
                    cnt_d = cnt_q + 7'd1;
                    if (cmp_valid_i && (cmp_accum_i < best_sad_q)) begin
                        best_sad_d = cmp_accum_i;
                        best_dx_d  = ref_dx_q;
                        best_dy_d  = ref_dy_q;
                    end
                    if (cand_last) begin
                        go_final = 1'b1;
                    end else begin
                        cand_next = 1'b1;
                        state_d   = S_SCAN;
                    end
                end
            end
            S_F_WAIT_DONE: begin
                if (cmp_rdy_i) begin
                    if (pass_q == 2'd2) begin
                        state_d = S_DONE;
                    end else begin
                        pass_d   = pass_q + 2'd1;
                        cc_d     = (pass_q == 2'd0) ? CC_U : CC_V;
                        ref_dx_d = half_vec(best_dx_q);
                        ref_dy_d = half_vec(best_dy_q);
                        state_d  = S_FINAL_ISSUE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Uses the _d best so a winning last candidate is replayed correctly.
        if (go_final) begin
            pass_d   = 2'd0;
            cc_d     = CC_Y;
            ref_dx_d = best_dx_d;
            ref_dy_d = best_dy_d;
            old_d    = SAD_MAX;
            state_d  = S_FINAL_ISSUE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            mb_x_q     <= '0;
            mb_y_q     <= '0;
            best_dx_q  <= '0;
            best_dy_q  <= '0;
            best_sad_q <= SAD_MAX;
            cnt_q      <= '0;
            ref_dx_q   <= '0;
            ref_dy_q   <= '0;
            cc_q       <= CC_Y;
            old_q      <= SAD_MAX;
            pass_q     <= '0;
            tmr_q      <= '0;
        end else begin
            state_q    <= state_d;
            mb_x_q     <= mb_x_d;
            mb_y_q     <= mb_y_d;
            best_dx_q  <= best_dx_d;
            best_dy_q  <= best_dy_d;
            best_sad_q <= best_sad_d;
            cnt_q      <= cnt_d;
            ref_dx_q   <= ref_dx_d;
            ref_dy_q   <= ref_dy_d;
            cc_q       <= cc_d;
            old_q      <= old_d;
            pass_q     <= pass_d;
            tmr_q      <= tmr_d;
        end
    end

    assign busy_o         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o         = (state_q == S_DONE);
    assign cmp_en_o       = cmp_en;
    assign cmp_cc_o       = cc_q;
    assign cmp_oldaccum_o = old_q;
    assign ref_dx_o       = ref_dx_q;
    assign ref_dy_o       = ref_dy_q;
    assign best_dx_o      = best_dx_q;
    assign best_dy_o      = best_dy_q;
    assign best_sad_o     = best_sad_q;
    assign cand_cnt_o     = cnt_q;

endmodule

// File: tb/tb_mv_search_ctrl.sv
// Bench for mv_search_ctrl with a behavioural blkcompare and a command scoreboard.
module tb_mv_search_ctrl;

    localparam int ACCW = 18;
    localparam int SMAX = (1 << ACCW) - 1;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic [4:0]      mb_x, mb_y;
    logic            busy, done, cmp_en;
    logic [1:0]      cmp_cc;
    logic [ACCW-1:0] cmp_oldaccum;
    logic            cmp_rdy;
    logic [ACCW-1:0] cmp_accum;
    logic            cmp_valid;
    logic [4:0]      ref_dx, ref_dy, best_dx, best_dy;
    logic [ACCW-1:0] best_sad;
    logic [6:0]      cand_cnt;

    int n_checks = 0;
    int n_fails  = 0;
    int sad_tab[81];
    logic hold_rdy = 1'b0;
    logic prev_en  = 1'b0;
    logic [29:0] exp_q[$];

    int            bcnt;
    logic [ACCW-1:0] pend_accum;
    logic            pend_valid;

    mv_search_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start_i        (start),
        .mb_x_i         (mb_x),
        .mb_y_i         (mb_y),
        .busy_o         (busy),
        .done_o         (done),
        .cmp_en_o       (cmp_en),
        .cmp_cc_o       (cmp_cc),
        .cmp_oldaccum_o (cmp_oldaccum),
        .cmp_rdy_i      (cmp_rdy),
        .cmp_accum_i    (cmp_accum),
        .cmp_valid_i    (cmp_valid),
        .ref_dx_o       (ref_dx),
        .ref_dy_o       (ref_dy),
        .best_dx_o      (best_dx),
        .best_dy_o      (best_dy),
        .best_sad_o     (best_sad),
        .cand_cnt_o     (cand_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int tidx(input int dx, input int dy);
        return (dy + 4) * 9 + (dx + 4);
    endfunction

    function automatic int model_sad(input logic [1:0] cc, input logic [4:0] dx, input logic [4:0] dy);
        int sdx, sdy;
        sdx = $signed(dx);
        sdy = $signed(dy);
        if (cc != 2'b00 || sdx < -4 || sdx > 4 || sdy < -4 || sdy > 4) return 7;
        return sad_tab[tidx(sdx, sdy)];
    endfunction

    function automatic logic [29:0] pack(input int cc, input int dx, input int dy, input int old);
        return {cc[1:0], dx[4:0], dy[4:0], old[17:0]};
    endfunction

    function automatic int half(input int v);
        return (v < 0) ? -((-v + 1) / 2) : v / 2;
    endfunction

    function automatic logic [31:0] v5(input int v);
        return {27'd0, v[4:0]};
    endfunction

    // blkcompare model: rdy low 20 cycles after en (or never, when hold_rdy)
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmp_rdy    <= 1'b1;
            cmp_accum  <= '0;
            cmp_valid  <= 1'b0;
            bcnt       <= 0;
            pend_accum <= '0;
            pend_valid <= 1'b0;
        end else if (cmp_en) begin
            if (hold_rdy) begin
                cmp_accum <= ACCW'(model_sad(cmp_cc, ref_dx, ref_dy));
                cmp_valid <= model_sad(cmp_cc, ref_dx, ref_dy) < int'(cmp_oldaccum);
            end else begin
                cmp_rdy    <= 1'b0;
                bcnt       <= 20;
                pend_accum <= ACCW'(model_sad(cmp_cc, ref_dx, ref_dy));
                pend_valid <= model_sad(cmp_cc, ref_dx, ref_dy) < int'(cmp_oldaccum);
            end
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) begin
                cmp_rdy   <= 1'b1;
                cmp_accum <= pend_accum;
                cmp_valid <= pend_valid;
            end
        end
    end

    // Command monitor: each cmp_en pops the next expected command.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_en = 1'b0;
        end else begin
            if (cmp_en) begin
                chk("en_back_to_back", {31'd0, prev_en}, 32'd0);
                chk("en_while_not_rdy", {31'd0, cmp_rdy}, 32'd1);
                chk("cmd_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0)
                    chk("cmd", {2'b00, cmp_cc, ref_dx, ref_dy, cmp_oldaccum}, {2'b00, exp_q.pop_front()});
            end
            prev_en = cmp_en;
        end
    end

    task automatic fill_table(input int base);
        for (int i = 0; i < 81; i++) sad_tab[i] = base + i;
    endtask

    task automatic build_expect(input int mx, input int my);
        int best, bdx, bdy, s;
        bit clipped;
        best = SMAX; bdx = 0; bdy = 0;
        for (int dy = -4; dy <= 4; dy++) begin
            for (int dx = -4; dx <= 4; dx++) begin
                clipped = (16*mx + dx < 0) || (16*mx + dx + 15 > 16*22 - 1)
                       || (16*my + dy < 0) || (16*my + dy + 15 > 16*18 - 1);
                if (dx == 0 && dy == 0) clipped = 1'b0;
                if (!clipped) begin
                    exp_q.push_back(pack(0, dx, dy, best));
                    s = sad_tab[tidx(dx, dy)];
                    if (s < best) begin best = s; bdx = dx; bdy = dy; end
                end
            end
        end
        exp_q.push_back(pack(0, bdx, bdy, SMAX));
        exp_q.push_back(pack(1, half(bdx), half(bdy), SMAX));
        exp_q.push_back(pack(2, half(bdx), half(bdy), SMAX));
    endtask

    task automatic start_search(input int mx, input int my);
        build_expect(mx, my);
        @(negedge clk);
        mb_x = 5'(mx); mb_y = 5'(my); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic finish_search(input string tag, input int e_cnt, input int e_dx, input int e_dy, input int e_sad);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_cand_cnt"}, {25'd0, cand_cnt}, 32'(e_cnt));
        chk({tag, "_best_dx"}, {27'd0, best_dx}, v5(e_dx));
        chk({tag, "_best_dy"}, {27'd0, best_dy}, v5(e_dy));
        chk({tag, "_best_sad"}, {14'd0, best_sad}, 32'(e_sad));
        chk({tag, "_cmds_left"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse_width"}, {31'd0, done}, 32'd0);
        chk({tag, "_held_cnt"}, {25'd0, cand_cnt}, 32'(e_cnt));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_en"}, {31'd0, cmp_en}, 32'd0);
        chk({tag, "_refs_cc"}, {20'd0, cmp_cc, ref_dx, ref_dy}, 32'd0);
        chk({tag, "_best_vec_cnt"}, {15'd0, best_dx, best_dy, cand_cnt}, 32'd0);
        chk({tag, "_best_sad"}, {14'd0, best_sad}, 32'(SMAX));
        chk({tag, "_oldaccum"}, {14'd0, cmp_oldaccum}, 32'(SMAX));
    endtask

    initial begin
        bit reached;
        reset_n = 1'b0; start = 1'b0; mb_x = '0; mb_y = '0;
        fill_table(500);
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: unique minimum at (+2,-1)
        fill_table(500); sad_tab[tidx(2, -1)] = 100;
        start_search(5, 5);
        finish_search("t1", 81, 2, -1, 100);

        // 2: frame corner, negative vectors clipped
        fill_table(500); sad_tab[tidx(3, 2)] = 150;
        start_search(0, 0);
        finish_search("t2", 25, 3, 2, 150);

        // 3: tie keeps the earlier candidate; oldaccum 200 checked by scoreboard
        for (int i = 0; i < 81; i++) sad_tab[i] = 500;
        sad_tab[tidx(-1, 0)] = 200; sad_tab[tidx(1, 0)] = 200;
        start_search(5, 5);
        finish_search("t3", 81, -1, 0, 200);

        // 4: odd negative/positive vector halves for chroma
        fill_table(500); sad_tab[tidx(-3, 3)] = 50;
        start_search(5, 5);
        finish_search("t4", 81, -3, 3, 50);

        // 5: asynchronous reset mid-search, then a fresh search
        fill_table(500); sad_tab[tidx(2, -1)] = 100;
        start_search(5, 5);
        reached = 1'b0;
        for (int i = 0; i < 3000 && !reached; i++) begin
            @(negedge clk);
            if (cand_cnt == 7'd39) reached = 1'b1;
        end
        chk("t5_reached_cand40", {31'd0, reached}, 32'd1);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("t5_reset");
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        start_search(5, 5);
        finish_search("t5", 81, 2, -1, 100);

        // 6: rdy never drops (timeout path) and start while busy
        hold_rdy = 1'b1;
        start_search(5, 5);
        repeat (3) @(negedge clk);
        mb_x = 5'd0; mb_y = 5'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t6_busy_after_ignored_start", {31'd0, busy}, 32'd1);
        finish_search("t6", 81, 2, -1, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
